// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned CNT_W  = 16;

  // Packet-tracking FSM encoding
  typedef logic [0:0] state_t;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  // A one-entry slot can take a beat when empty or when draining this cycle
  function automatic logic slot_can_accept(input logic valid, input logic ready);
    return (!valid) || ready;
  endfunction

endpackage

// File: rtl/m_out_slot.sv
// One-entry registered output stage with valid/ready handshake.
// Optional DEMUX_PKT_CNT_EN adds a completed-packet counter (handshakes with last=1).
module m_out_slot
  import demux_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          accept_c
`ifdef DEMUX_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt
`endif
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q,  data_d;
  logic          last_q,  last_d;
  logic          drain;

  // Slot next-state: load wins over drain so a same-cycle drain+load keeps it full
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    drain    = valid_q && out_ready;
    accept_c = slot_can_accept(valid_q, out_ready);
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

`ifdef DEMUX_PKT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count packets leaving this output; wraps naturally at 2^CNT_W
  always_comb begin
    cnt_d = cnt_q;
    if (drain && last_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: rtl/m_stream_demux2.sv
// Registered 1-to-2 packet stream demultiplexer.
// Route is taken from w_sel on a packet's first beat and held until its last beat.
// Optional DEMUX_PKT_CNT_EN exposes per-output completed-packet counters.
module m_stream_demux2
  import demux_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  input  logic          w_in_valid,
  output logic          w_in_ready,
  input  logic [DW-1:0] w_in_data,
  input  logic          w_in_last,
  input  logic          w_sel,
  output logic          w_out0_valid,
  input  logic          w_out0_ready,
  output logic [DW-1:0] w_out0_data,
  output logic          w_out0_last,
  output logic          w_out1_valid,
  input  logic          w_out1_ready,
  output logic [DW-1:0] w_out1_data,
  output logic          w_out1_last
`ifdef DEMUX_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0] w_cnt0,
  output logic [CNT_W-1:0] w_cnt1
`endif
);

  state_t state_q, state_d;
  logic   route_q, route_d;
  logic   route_c;
  logic   accept_c;
  logic   load0_c, load1_c;
  logic   slot0_accept_c, slot1_accept_c;

  // Route selection, input ready and per-slot load strobes
  always_comb begin
    route_c    = (state_q == ST_PKT) ? route_q : w_sel;
    w_in_ready = route_c ? slot1_accept_c : slot0_accept_c;
    accept_c   = w_in_valid && w_in_ready;
    load0_c    = accept_c && !route_c;
    load1_c    = accept_c &&  route_c;
  end

  // Packet FSM next-state: open on a non-last first beat, close on a last beat
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c && !w_in_last) begin
          state_d = ST_PKT;
          route_d = w_sel;
        end
      end
      ST_PKT: begin
        if (accept_c && w_in_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and latched route registers
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= ST_IDLE;
      route_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  m_out_slot #(
    .DW (DW)
  ) u_slot0 (
    .clk       (w_clk),
    .rst_n     (w_rst_n),
    .load      (load0_c),
    .load_data (w_in_data),
    .load_last (w_in_last),
    .out_ready (w_out0_ready),
    .out_valid (w_out0_valid),
    .out_data  (w_out0_data),
    .out_last  (w_out0_last),
    .accept_c  (slot0_accept_c)
`ifdef DEMUX_PKT_CNT_EN
    ,
    .pkt_cnt   (w_cnt0)
`endif
  );

  m_out_slot #(
    .DW (DW)
  ) u_slot1 (
    .clk       (w_clk),
    .rst_n     (w_rst_n),
    .load      (load1_c),
    .load_data (w_in_data),
    .load_last (w_in_last),
    .out_ready (w_out1_ready),
    .out_valid (w_out1_valid),
    .out_data  (w_out1_data),
    .out_last  (w_out1_last),
    .accept_c  (slot1_accept_c)
`ifdef DEMUX_PKT_CNT_EN
    ,
    .pkt_cnt   (w_cnt1)
`endif
  );

endmodule

// File: tb/tb_m_stream_demux2.sv
// Directed self-checking bench for m_stream_demux2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_m_stream_demux2;

  localparam int unsigned DW = 32;

  logic          w_clk;
  logic          w_rst_n;
  logic          w_in_valid;
  logic          w_in_ready;
  logic [DW-1:0] w_in_data;
  logic          w_in_last;
  logic          w_sel;
  logic          w_out0_valid, w_out1_valid;
  logic          w_out0_ready, w_out1_ready;
  logic [DW-1:0] w_out0_data, w_out1_data;
  logic          w_out0_last, w_out1_last;
`ifdef DEMUX_PKT_CNT_EN
  logic [15:0]   w_cnt0, w_cnt1;
`endif

  int n_checks;
  int n_fail;

  m_stream_demux2 #(.DW(DW)) dut (
    .w_clk        (w_clk),
    .w_rst_n      (w_rst_n),
    .w_in_valid   (w_in_valid),
    .w_in_ready   (w_in_ready),
    .w_in_data    (w_in_data),
    .w_in_last    (w_in_last),
    .w_sel        (w_sel),
    .w_out0_valid (w_out0_valid),
    .w_out0_ready (w_out0_ready),
    .w_out0_data  (w_out0_data),
    .w_out0_last  (w_out0_last),
    .w_out1_valid (w_out1_valid),
    .w_out1_ready (w_out1_ready),
    .w_out1_data  (w_out1_data),
    .w_out1_last  (w_out1_last)
`ifdef DEMUX_PKT_CNT_EN
    ,
    .w_cnt0       (w_cnt0),
    .w_cnt1       (w_cnt1)
`endif
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d, input logic l);
    w_in_valid = v;
    w_sel      = s;
    w_in_data  = d;
    w_in_last  = l;
  endtask

  task automatic step();
    @(negedge w_clk);
  endtask

  task automatic test_reset();
    w_rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    w_out0_ready = 1'b1;
    w_out1_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (w_out0_valid !== 1'b0 || w_out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: out0_valid=%b out1_valid=%b expected 0/0", w_out0_valid, w_out1_valid);
    end
    n_checks++;
    if (w_out0_data !== '0 || w_out1_data !== '0 || w_out0_last !== 1'b0 || w_out1_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: out0=%h/%b out1=%h/%b expected zeros", w_out0_data, w_out0_last, w_out1_data, w_out1_last);
    end
    w_rst_n = 1'b1;
    step();
    n_checks++;
    if (w_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready_idle: got %b expected 1", w_in_ready);
    end
    // three beats of an open packet to out1
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, DW'(32'h0000_0700 + i), 1'b0);
      step();
    end
    n_checks++;
    if (w_out1_valid !== 1'b1 || w_out1_data !== 32'h0000_0702) begin
      n_fail++;
      $display("FAIL reset_prefill: out1_valid=%b data=%h expected 1/00000702", w_out1_valid, w_out1_data);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    #2 w_rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_out0_valid !== 1'b0 || w_out1_valid !== 1'b0 || w_out1_data !== '0) begin
      n_fail++;
      $display("FAIL reset_midpkt: out0_valid=%b out1_valid=%b out1_data=%h expected 0/0/0", w_out0_valid, w_out1_valid, w_out1_data);
    end
    step();
    w_rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_0055, 1'b1);
    step();
    drive(1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (w_out0_valid !== 1'b1 || w_out0_data !== 32'h0000_0055 || w_out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_next_pkt: out0_valid=%b out0_data=%h out1_valid=%b expected 1/00000055/0", w_out0_valid, w_out0_data, w_out1_valid);
    end
    step();
  endtask

  task automatic test_packet_hold();
    logic [DW-1:0] exp_d;
    w_out0_ready = 1'b1;
    w_out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_d = DW'(32'h10 + i);
      drive(1'b1, (i % 2 == 0), exp_d, (i == 3));
      #1;
      n_checks++;
      if (w_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_in_ready beat%0d: got %b expected 1", i, w_in_ready);
      end
      step();
      n_checks++;
      if (w_out1_valid !== 1'b1 || w_out1_data !== exp_d || w_out1_last !== (i == 3) || w_out0_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_beat%0d: out1 v=%b d=%h l=%b out0_v=%b expected 1/%h/%b/0",
                 i, w_out1_valid, w_out1_data, w_out1_last, w_out0_valid, exp_d, (i == 3));
      end
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    n_checks++;
    if (w_out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drained: out1_valid=%b expected 0", w_out1_valid);
    end
  endtask

  task automatic test_back_to_back();
    w_out0_ready = 1'b1;
    w_out1_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_000A, 1'b1);
    step();
    n_checks++;
    if (w_out0_valid !== 1'b1 || w_out0_data !== 32'h0000_000A || w_out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_A: out0 v=%b d=%h out1_v=%b expected 1/0000000a/0", w_out0_valid, w_out0_data, w_out1_valid);
    end
    drive(1'b1, 1'b1, 32'h0000_000B, 1'b1);
    step();
    n_checks++;
    if (w_out1_valid !== 1'b1 || w_out1_data !== 32'h0000_000B || w_out0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_B: out1 v=%b d=%h out0_v=%b expected 1/0000000b/0", w_out1_valid, w_out1_data, w_out0_valid);
    end
    drive(1'b1, 1'b0, 32'h0000_000C, 1'b1);
    step();
    n_checks++;
    if (w_out0_valid !== 1'b1 || w_out0_data !== 32'h0000_000C || w_out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_C: out0 v=%b d=%h out1_v=%b expected 1/0000000c/0", w_out0_valid, w_out0_data, w_out1_valid);
    end
    // still IDLE: the next beat follows its own w_sel
    drive(1'b1, 1'b1, 32'h0000_000D, 1'b1);
    step();
    n_checks++;
    if (w_out1_valid !== 1'b1 || w_out1_data !== 32'h0000_000D || w_out0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: out1 v=%b d=%h out0_v=%b expected 1/0000000d/0", w_out1_valid, w_out1_data, w_out0_valid);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    w_out0_ready = 1'b0;
    w_out1_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_CAFE, 1'b1);
    step();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        drive(1'b1, 1'b1, 32'h0000_1234, 1'b1);
        #1;
        n_checks++;
        if (w_in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_out1_ready: got %b expected 1", w_in_ready);
        end
      end else begin
        drive(1'b1, 1'b0, 32'h0000_BEEF, 1'b1);
        #1;
        n_checks++;
        if (w_in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_out0_stall cyc%0d: in_ready=%b expected 0", c, w_in_ready);
        end
      end
      step();
      n_checks++;
      if (w_out0_valid !== 1'b1 || w_out0_data !== 32'h0000_CAFE || w_out0_last !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: out0 v=%b d=%h l=%b expected 1/0000cafe/1", c, w_out0_valid, w_out0_data, w_out0_last);
      end
      if (c == 2) begin
        n_checks++;
        if (w_out1_valid !== 1'b1 || w_out1_data !== 32'h0000_1234) begin
          n_fail++;
          $display("FAIL bp_out1_pass: out1 v=%b d=%h expected 1/00001234", w_out1_valid, w_out1_data);
        end
      end
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    w_out0_ready = 1'b1;
    step();
    n_checks++;
    if (w_out0_valid !== 1'b0 || w_out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: out0_v=%b out1_v=%b expected 0/0", w_out0_valid, w_out1_valid);
    end
  endtask

  task automatic test_drain_load();
    logic [DW-1:0] exp_d;
    w_out0_ready = 1'b1;
    w_out1_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_d = DW'(32'h100 + i);
      drive(1'b1, 1'b0, exp_d, (i == 7));
      #1;
      n_checks++;
      if (w_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dl_in_ready beat%0d: got %b expected 1", i, w_in_ready);
      end
      step();
      n_checks++;
      if (w_out0_valid !== 1'b1 || w_out0_data !== exp_d || w_out0_last !== (i == 7)) begin
        n_fail++;
        $display("FAIL dl_beat%0d: out0 v=%b d=%h l=%b expected 1/%h/%b", i, w_out0_valid, w_out0_data, w_out0_last, exp_d, (i == 7));
      end
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    n_checks++;
    if (w_out0_valid !== 1'b0 || w_out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_drained: out0_v=%b out1_v=%b expected 0/0", w_out0_valid, w_out1_valid);
    end
    w_out1_ready = 1'b1;
  endtask

`ifdef DEMUX_PKT_CNT_EN
  task automatic test_counter_wrap();
    w_rst_n = 1'b0;
    step();
    w_rst_n = 1'b1;
    w_out0_ready = 1'b1;
    w_out1_ready = 1'b1;
    n_checks++;
    if (w_cnt0 !== 16'h0 || w_cnt1 !== 16'h0) begin
      n_fail++;
      $display("FAIL cnt_reset: cnt0=%h cnt1=%h expected 0/0", w_cnt0, w_cnt1);
    end
    drive(1'b1, 1'b1, 32'h0000_0001, 1'b1);
    for (int i = 0; i < 65535; i++) step();
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    n_checks++;
    if (w_cnt1 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_max: cnt1=%h expected ffff", w_cnt1);
    end
    drive(1'b1, 1'b1, 32'h0000_0002, 1'b1);
    step();
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    n_checks++;
    if (w_cnt1 !== 16'h0 || w_cnt0 !== 16'h0) begin
      n_fail++;
      $display("FAIL cnt_wrap: cnt1=%h cnt0=%h expected 0/0", w_cnt1, w_cnt0);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_packet_hold();
    test_back_to_back();
    test_backpressure();
    test_drain_load();
`ifdef DEMUX_PKT_CNT_EN
    test_counter_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
